// File: rtl/bcd_pkg.sv
// Shared types and helpers for the chained BCD counter.
// Digit moduli alternate between even (MOD_LO) and odd (MOD_HI) positions.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  // Modulus of digit position i: even positions use mod_lo, odd positions use mod_hi.
  function automatic bcd_t digit_mod(input int i, input int mod_lo, input int mod_hi);
    if ((i % 2) == 0) begin
      return bcd_t'(mod_lo);
    end
    return bcd_t'(mod_hi);
  endfunction

endpackage

// File: rtl/bcd_chain_counter_if.sv
// Control and data bundle between a controller and the chained BCD counter.
// Strobe semantics: there is no valid/ready pair; ad/clr/ld are sampled on every
// rising edge and act in that edge; digits/ovf/unf are registered, carry is comb.
interface bcd_chain_counter_if #(
  parameter int DIGITS = 4
);

  logic                  stp;
  logic                  ad;
  logic                  dn;
  logic                  clr;
  logic                  ld;
  logic [4*DIGITS-1:0]   ld_val;
  logic [4*DIGITS-1:0]   digits;
  logic                  carry;
  logic                  ovf;
  logic                  unf;

  modport master (
    output stp,
    output ad,
    output dn,
    output clr,
    output ld,
    output ld_val,
    input  digits,
    input  carry,
    input  ovf,
    input  unf
  );

  modport slave (
    input  stp,
    input  ad,
    input  dn,
    input  clr,
    input  ld,
    input  ld_val,
    output digits,
    output carry,
    output ovf,
    output unf
  );

endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD digit with a runtime modulus: clear, clamped load, and up/down step.
// at_lim flags the value at which this digit passes a borrow/carry onward.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  bcd_t mod,
  input  logic en,
  input  logic dn,
  input  logic clr,
  input  logic ld,
  input  bcd_t ld_d,
  output bcd_t q,
  output logic at_lim
);

  bcd_t q_q;
  bcd_t q_d;
  bcd_t top_val;

  assign top_val = mod - bcd_t'(1);

  always_comb begin
    at_lim = 1'b0;
    if (dn) begin
      at_lim = (q_q == '0);
    end else begin
      at_lim = (q_q == top_val);
    end
  end

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (ld) begin
      // Out-of-range nibbles are clamped so no illegal value is ever stored.
      if (ld_d >= mod) begin
        q_d = top_val;
      end else begin
        q_d = ld_d;
      end
    end else if (en) begin
      if (dn) begin
        if (q_q == '0) begin
          q_d = top_val;
        end else begin
          q_d = q_q - bcd_t'(1);
        end
      end else begin
        if (q_q == top_val) begin
          q_d = '0;
        end else begin
          q_d = q_q + bcd_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bcd_chain_counter.sv
// Multi-digit BCD counter: ripple enable chain over per-digit cells, with a
// combinational whole-chain carry and registered one-cycle ovf/unf pulses.
module bcd_chain_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int MOD_LO   = 10,
  parameter int MOD_HI   = 10,
  parameter int SATURATE = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  bcd_chain_counter_if.slave  bus
);

  localparam logic SAT_EN = (SATURATE != 0);

  bcd_t              digit_q [DIGITS];
  logic [DIGITS-1:0] at_lim;
  logic [DIGITS-1:0] dig_en;
  logic [DIGITS:0]   lim_below;
  logic              step_req;
  logic              step;
  logic              chain_lim;
  logic              carry;
  logic              ovf_q;
  logic              ovf_d;
  logic              unf_q;
  logic              unf_d;

  assign step_req = bus.ad & ~bus.stp & ~bus.clr & ~bus.ld;

  // lim_below[i] is high when every digit below position i sits at its limit.
  always_comb begin
    lim_below    = '0;
    lim_below[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      lim_below[i+1] = lim_below[i] & at_lim[i];
    end
  end

  assign chain_lim = lim_below[DIGITS];

  // In saturate mode a step that would wrap the whole chain is dropped.
  assign step  = step_req & ~(SAT_EN & chain_lim);
  assign carry = step_req & chain_lim & ~SAT_EN;

  always_comb begin
    dig_en = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig_en[i] = step & lim_below[i];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    localparam bcd_t DIG_MOD = digit_mod(g, MOD_LO, MOD_HI);

    bcd_digit_cell u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .mod     (DIG_MOD),
      .en      (dig_en[g]),
      .dn      (bus.dn),
      .clr     (bus.clr),
      .ld      (bus.ld),
      .ld_d    (bus.ld_val[g*BCD_W +: BCD_W]),
      .q       (digit_q[g]),
      .at_lim  (at_lim[g])
    );

    assign bus.digits[g*BCD_W +: BCD_W] = digit_q[g];
  end

  always_comb begin
    ovf_d = carry & ~bus.dn;
    unf_d = carry & bus.dn;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.carry = carry;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Bench for bcd_chain_counter: a wrapping and a saturating instance (mm:ss moduli)
// driven in parallel and compared against a mixed-radix integer reference model.
module tb_bcd_chain_counter;

  localparam int ND  = 4;
  localparam int MLO = 10;
  localparam int MHI = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stp;
  logic        ad;
  logic        dn;
  logic        clr;
  logic        ld;
  logic [15:0] ld_val;

  int n_checks = 0;
  int n_fail   = 0;

  int v0;
  int v1;
  bit ovf0_e;
  bit unf0_e;
  bit ovf1_e;
  bit unf1_e;
  int total;

  always #5 clk = ~clk;

  bcd_chain_counter_if #(.DIGITS(ND)) if0 ();
  bcd_chain_counter_if #(.DIGITS(ND)) if1 ();

  assign if0.stp    = stp;
  assign if0.ad     = ad;
  assign if0.dn     = dn;
  assign if0.clr    = clr;
  assign if0.ld     = ld;
  assign if0.ld_val = ld_val;
  assign if1.stp    = stp;
  assign if1.ad     = ad;
  assign if1.dn     = dn;
  assign if1.clr    = clr;
  assign if1.ld     = ld;
  assign if1.ld_val = ld_val;

  bcd_chain_counter #(.DIGITS(ND), .MOD_LO(MLO), .MOD_HI(MHI), .SATURATE(0)) u_wrap (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if0)
  );

  bcd_chain_counter #(.DIGITS(ND), .MOD_LO(MLO), .MOD_HI(MHI), .SATURATE(1)) u_sat (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if1)
  );

  function automatic int mod_of(input int i);
    return ((i % 2) == 0) ? MLO : MHI;
  endfunction

  function automatic int total_count();
    int p = 1;
    for (int i = 0; i < ND; i++) p = p * mod_of(i);
    return p;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    int          x = v;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(x % mod_of(i));
      x = x / mod_of(i);
    end
    return r;
  endfunction

  function automatic int from_ld(input logic [15:0] x);
    int v = 0;
    int w = 1;
    int d;
    for (int i = 0; i < ND; i++) begin
      d = int'(x[i*4 +: 4]);
      if (d >= mod_of(i)) d = mod_of(i) - 1;
      v = v + d * w;
      w = w * mod_of(i);
    end
    return v;
  endfunction

  // Next count as an integer in [0, total) from the current bench inputs.
  function automatic void model_step(input int v, input bit sat, output int nv, output bit cy);
    nv = v;
    cy = 1'b0;
    if (clr) begin
      nv = 0;
    end else if (ld) begin
      nv = from_ld(ld_val);
    end else if (ad && !stp) begin
      if (!dn) begin
        if (v == total - 1) begin
          if (!sat) begin nv = 0; cy = 1'b1; end
        end else begin
          nv = v + 1;
        end
      end else begin
        if (v == 0) begin
          if (!sat) begin nv = total - 1; cy = 1'b1; end
        end else begin
          nv = v - 1;
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("digits_wrap", 32'(if0.digits), 32'(to_bcd(v0)));
    check("ovf_wrap", 32'(if0.ovf), 32'(ovf0_e));
    check("unf_wrap", 32'(if0.unf), 32'(unf0_e));
    check("digits_sat", 32'(if1.digits), 32'(to_bcd(v1)));
    check("ovf_sat", 32'(if1.ovf), 32'(ovf1_e));
    check("unf_sat", 32'(if1.unf), 32'(unf1_e));
  endtask

  // One clock: carry checked mid-cycle, registered outputs checked just after the edge.
  task automatic tick();
    int nv0;
    int nv1;
    bit cy0;
    bit cy1;
    model_step(v0, 1'b0, nv0, cy0);
    model_step(v1, 1'b1, nv1, cy1);
    @(negedge clk);
    check("carry_wrap", 32'(if0.carry), 32'(cy0));
    check("carry_sat", 32'(if1.carry), 32'(cy1));
    @(posedge clk);
    v0     = nv0;
    v1     = nv1;
    ovf0_e = cy0 & !dn;
    unf0_e = cy0 & dn;
    ovf1_e = cy1 & !dn;
    unf1_e = cy1 & dn;
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    v0 = 0; v1 = 0;
    ovf0_e = 1'b0; unf0_e = 1'b0; ovf1_e = 1'b0; unf1_e = 1'b0;
  endtask

  initial begin
    logic [15:0] pick [5];
    total   = total_count();
    reset_n = 1'b0;
    stp = 1'b0; ad = 1'b0; dn = 1'b0; clr = 1'b0; ld = 1'b0; ld_val = '0;
    model_reset();

    // Reset state
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();

    // Count 7 steps, then asynchronous reset between edges
    ad = 1'b1;
    repeat (7) tick();
    check("count7", 32'(if0.digits), 32'h0007);
    ad = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("reset_digits", 32'(if0.digits), 32'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    ad = 1'b1;
    tick();
    check("first_after_reset", 32'(if0.digits), 32'h0001);

    // Up-wrap from 59:59 with a single ovf pulse
    ad = 1'b0; ld = 1'b1; ld_val = 16'h5959;
    tick();
    ld = 1'b0; ad = 1'b1;
    tick();
    check("upwrap_digits", 32'(if0.digits), 32'h0000);
    check("upwrap_ovf", 32'(if0.ovf), 32'h1);
    check("sat_hold_max", 32'(if1.digits), 32'h5959);
    ad = 1'b0;
    tick();

    // Down-wrap from 00:00 with a single unf pulse
    ld = 1'b1; ld_val = 16'h0000; dn = 1'b1;
    tick();
    ld = 1'b0; ad = 1'b1;
    tick();
    check("downwrap_digits", 32'(if0.digits), 32'h5959);
    check("downwrap_unf", 32'(if0.unf), 32'h1);
    check("sat_hold_zero", 32'(if1.digits), 32'h0000);
    ad = 1'b0;
    tick();

    // Digit rollovers without chain carry
    dn = 1'b0; ld = 1'b1; ld_val = 16'h0009;
    tick();
    ld = 1'b0; ad = 1'b1;
    tick();
    check("roll_0010", 32'(if0.digits), 32'h0010);
    ad = 1'b0; ld = 1'b1; ld_val = 16'h0059;
    tick();
    ld = 1'b0; ad = 1'b1;
    tick();
    check("roll_0100", 32'(if0.digits), 32'h0100);

    // Stop suppresses counting but not load; load clamps nibbles
    stp = 1'b1;
    repeat (5) tick();
    check("stp_hold", 32'(if0.digits), 32'h0100);
    ld = 1'b1; ld_val = 16'h7A3C;
    tick();
    check("ld_clamp", 32'(if0.digits), 32'h5939);
    ld = 1'b0; stp = 1'b0; ad = 1'b0;

    // Clear wins over load
    clr = 1'b1; ld = 1'b1; ld_val = 16'h1234;
    tick();
    check("clr_over_ld", 32'(if0.digits), 32'h0000);
    clr = 1'b0; ld = 1'b0;

    // Saturating instance holds at 59:59 going up and 00:00 going down
    ld = 1'b1; ld_val = 16'h5959;
    tick();
    ld = 1'b0; ad = 1'b1;
    repeat (3) tick();
    check("sat_up_hold", 32'(if1.digits), 32'h5959);
    dn = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (3) tick();
    check("sat_dn_hold", 32'(if1.digits), 32'h0000);

    // Randomized traffic, biased toward loads near the chain limits
    pick[0] = 16'h5959; pick[1] = 16'h0000; pick[2] = 16'h5958;
    pick[3] = 16'h0001; pick[4] = 16'h0959;
    for (int k = 0; k < 600; k++) begin
      stp = ($urandom_range(0, 7) == 0);
      ad  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) dn = ~dn;
      clr = ($urandom_range(0, 63) == 0);
      ld  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 2) == 0) ld_val = 16'($urandom);
      else ld_val = pick[$urandom_range(0, 4)];
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
